jpeg_raster_to_block: RTL and testbench
=======================================

# jpeg_raster_to_block

Upstream feeder for the JPEG encoder wrapper. Accepts RGB pixels in raster-scan order, buffers one 8-line strip in a double-banked line buffer, and re-emits the pixels as 8x8 blocks in block order. Each block is 64 row-major beats. The final block of the image is flagged. The output stream is what the encoder consumes as its 64-pixel write bursts.

## Interface

- MAX_WIDTH, 640: maximum image width in pixels; must be a multiple of 8.
- PIX_W, 24: input pixel width; packed {R,G,B}.

- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; samples config and begins a frame.
- cfg_width_blks  in  $clog2(MAX_WIDTH/8)+1  image width in 8-pixel blocks.
- cfg_height_strips  in  16  image height in 8-line strips.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- in_data  in  PIX_W  raster pixel.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  32  {8'h00, pixel}.
- out_last_blk  out  1  high on all 64 beats of the image's final block.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final beat handshake.
- cfg_err  out  1  one-cycle pulse when start is rejected.

## Operation

- Storage: 2 banks; each bank is 8 lines x MAX_WIDTH pixels. Write address = row*MAX_WIDTH + col. Read address = row*MAX_WIDTH + blk*8 + j.
- Frame start: start is honoured only when !busy. config_ok = cfg_width_blks in 1..MAX_WIDTH/8 and cfg_height_strips != 0.
  - config_ok false: cfg_err pulses and the block stays idle.
  - config_ok true: latches config, busy=1, clears both bank_full flags, wr_bank=rd_bank=0. start while busy is ignored and does not raise cfg_err.
- Fill FSM (F_IDLE, F_FILL, F_WAIT):
  - F_FILL: in_ready = !bank_full[wr_bank]. Counters col (0..W*8-1) and row (0..7) advance on each accepted pixel.
  - On the strip's last pixel: set bank_full[wr_bank] and toggle wr_bank. Increment the strip count, then go to F_IDLE if it equals cfg_height_strips, else stay in F_FILL.
  - F_WAIT is entered when the target bank is full; in_ready=0 there.
- Drain FSM (D_IDLE, D_RUN):
  - Leaves D_IDLE when bank_full[rd_bank].
  - Counters blk (0..W-1), row (0..7) and j (0..7) step in j, then row, then blk order.
  - After beat 64*W of the strip: clear bank_full[rd_bank] and toggle rd_bank.
  - out_last_blk = (final strip) && (blk == W-1).
- Same-cycle set and clear on different banks are both honoured. The fill side never writes a bank whose bank_full=1.
- done pulses on the cycle after the final beat handshake, and busy falls on that same cycle.
- No input is accepted when busy=0 (in_ready=0).

## Timing

- Reset values: in_ready=0, out_valid=0, out_data=0, out_last_blk=0, busy=0, done=0, cfg_err=0. Both FSMs reset to IDLE and all bank_full flags clear. RAM contents are don't-care.
- Reset mid-frame aborts immediately; no done pulse follows.
- RAM has 1-cycle read latency. The 2-entry output buffer (read stage + output register) sustains 1 beat/cycle when out_ready stays high.
- Latency: last pixel of a strip accepted in cycle N with drain idle gives first out_valid in cycle N+2.
- Handshake rules:
  - out_valid must not drop until the beat is taken.
  - out_data and out_last_blk must stay stable while out_valid && !out_ready.
  - There is no combinational path from out_ready to in_ready.
- Fill and drain overlap, so steady-state input throughput is 1 pixel/cycle with out_ready=1.

## Test plan

- W=1, H=1, in_data=0..63 -> out_data 0..63 in order; out_last_blk=1 on all 64 beats; done exactly once, 2 cycles after the last input plus 64 beats.
- W=2, H=1, pixel = x + 16*y -> block 0 emits 0..7, 16..23, …, 112..119; block 1 emits 8..15, …; out_last_blk only on block 1.
- W=1, H=3, out_ready=0 -> exactly 128 pixels accepted, then in_ready=0. Releasing out_ready yields 192 beats in order with out_last_blk on beats 128..191.
- Random out_ready (50%) on W=4, H=2 -> no lost, duplicated or reordered beats; out_data stable during stalls.
- start with cfg_width_blks=0, then with cfg_width_blks=MAX_WIDTH/8+1, then with cfg_height_strips=0 -> cfg_err pulses each time; busy stays 0.
- rst asserted after 100 pixels of a W=2, H=2 frame -> all outputs at reset values next cycle. A following W=1, H=1 frame completes correctly with no stale data.

Source files
------------

// File: rtl/jpeg_raster_to_block.sv
// jpeg_raster_to_block
//   Converts a raster-scan RGB pixel stream into 8x8 blocks in block order.
//   One 8-line strip is buffered per bank; two banks let the fill of strip
//   s+1 overlap the drain of strip s. Each block leaves as 64 row-major beats.
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   start              one-cycle pulse, samples config and starts a frame
//   cfg_width_blks     image width in 8-pixel blocks (1..MAX_WIDTH/8)
//   cfg_height_strips  image height in 8-line strips (non-zero)
//   in_valid/in_ready/in_data      raster pixel input, packed {R,G,B}
//   out_valid/out_ready/out_data   block-ordered output, {8'h00, pixel}
//   out_last_blk       set on all 64 beats of the image's final block
//   busy               frame in progress
//   done               one-cycle pulse after the final beat handshake
//   cfg_err            one-cycle pulse when start is rejected
module jpeg_raster_to_block #(
  parameter int MAX_WIDTH = 640,
  parameter int PIX_W     = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(MAX_WIDTH/8):0]   cfg_width_blks,
  input  logic [15:0]                    cfg_height_strips,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PIX_W-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_data,
  output logic                           out_last_blk,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int BW      = $clog2(MAX_WIDTH/8) + 1;
  localparam int CW      = BW + 3;
  localparam int BANK_SZ = 8 * MAX_WIDTH;
  localparam int DEPTH   = 2 * BANK_SZ;
  localparam int AW      = $clog2(DEPTH);

  typedef enum logic [1:0] {F_IDLE = 2'd0, F_FILL = 2'd1, F_WAIT = 2'd2} fill_t;
  typedef enum logic       {D_IDLE = 1'b0, D_RUN = 1'b1} drain_t;

  fill_t             fill_q, fill_d;
  drain_t            drain_q, drain_d;
  logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic              in_ready_q, in_ready_d;
  logic [BW-1:0]     cfg_w_q, cfg_w_d, blk_q, blk_d;
  logic [15:0]       cfg_h_q, cfg_h_d, fstrip_q, fstrip_d, dstrip_q, dstrip_d;
  logic [1:0]        bank_full_q, bank_full_d, bank_full_nxt, set_mask, clr_mask;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [CW-1:0]     col_q, col_d;
  logic [2:0]        frow_q, frow_d, drow_q, drow_d, j_q, j_d;
  logic              s1_v_q, s1_v_d, s1_last_q, s1_last_d, s1_fin_q, s1_fin_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d, out_fin_q, out_fin_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [PIX_W-1:0]  s1_data_q;
  logic [PIX_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_addr, rd_addr;
  logic              wr_en, rd_en, col_last, strip_set, strip_end;
  logic              s2_take, room, avail, blk_last, final_strip, cfg_ok;

  // Fill-side write strobe and end-of-strip detection.
  always_comb begin
    wr_en     = in_valid && in_ready_q;
    col_last  = (col_q + CW'(1)) == {cfg_w_q, 3'b000};
    strip_set = wr_en && col_last && (frow_q == 3'd7);
  end

  // Drain-side read issue and bank-full set/clear masks.
  always_comb begin
    s2_take     = !out_valid_q || out_ready;
    room        = !s1_v_q || s2_take;
    // A strip completing this cycle may start draining at once: its first
    // read (row 0) never collides with the write of its last pixel (row 7).
    avail       = bank_full_q[rd_bank_q] || (strip_set && (wr_bank_q == rd_bank_q));
    rd_en       = busy_q && room && ((drain_q == D_RUN) || avail);
    blk_last    = (blk_q == (cfg_w_q - BW'(1)));
    strip_end   = rd_en && blk_last && (drow_q == 3'd7) && (j_q == 3'd7);
    final_strip = (dstrip_q == (cfg_h_q - 16'd1));
    set_mask    = 2'b00;
    clr_mask    = 2'b00;
    if (strip_set) begin
      set_mask[wr_bank_q] = 1'b1;
    end else begin
      set_mask = 2'b00;
    end
    if (strip_end) begin
      clr_mask[rd_bank_q] = 1'b1;
    end else begin
      clr_mask = 2'b00;
    end
    bank_full_nxt = (bank_full_q & ~clr_mask) | set_mask;
  end

  // RAM addresses: bank, line within the strip, pixel column.
  always_comb begin
    wr_addr = AW'(wr_bank_q) * AW'(BANK_SZ) + AW'(frow_q) * AW'(MAX_WIDTH) + AW'(col_q);
    rd_addr = AW'(rd_bank_q) * AW'(BANK_SZ) + AW'(drow_q) * AW'(MAX_WIDTH) + AW'({blk_q, j_q});
  end

  // Next-state logic for frame control, fill FSM, drain FSM and output stage.
  always_comb begin
    busy_d = busy_q;  cfg_w_d = cfg_w_q;  cfg_h_d = cfg_h_q;
    fill_d = fill_q;  drain_d = drain_q;  bank_full_d = bank_full_nxt;
    wr_bank_d = wr_bank_q;  rd_bank_d = rd_bank_q;
    col_d = col_q;  frow_d = frow_q;  fstrip_d = fstrip_q;
    blk_d = blk_q;  drow_d = drow_q;  j_d = j_q;  dstrip_d = dstrip_q;
    s1_v_d = s1_v_q;  s1_last_d = s1_last_q;  s1_fin_d = s1_fin_q;
    out_valid_d = out_valid_q;  out_data_d = out_data_q;
    out_last_d = out_last_q;  out_fin_d = out_fin_q;
    done_d = 1'b0;  cfg_err_d = 1'b0;
    cfg_ok = (cfg_width_blks != {BW{1'b0}}) && (cfg_width_blks <= BW'(MAX_WIDTH/8))
             && (cfg_height_strips != 16'd0);

    case (fill_q)
      F_FILL: begin
        if (wr_en && col_last && (frow_q == 3'd7)) begin
          col_d     = {CW{1'b0}};
          frow_d    = 3'd0;
          wr_bank_d = ~wr_bank_q;
          fstrip_d  = fstrip_q + 16'd1;
          if ((fstrip_q + 16'd1) == cfg_h_q) begin
            fill_d = F_IDLE;
          end else if (bank_full_nxt[~wr_bank_q]) begin
            fill_d = F_WAIT;
          end else begin
            fill_d = F_FILL;
          end
        end else if (wr_en && col_last) begin
          col_d  = {CW{1'b0}};
          frow_d = frow_q + 3'd1;
        end else if (wr_en) begin
          col_d = col_q + CW'(1);
        end else begin
          col_d = col_q;
        end
      end
      F_WAIT: begin
        if (!bank_full_nxt[wr_bank_q]) begin
          fill_d = F_FILL;
        end else begin
          fill_d = F_WAIT;
        end
      end
      F_IDLE:  fill_d = F_IDLE;
      default: fill_d = F_IDLE;
    endcase

    // Read issue walks j, then row, then block; tags ride with the data.
    if (rd_en) begin
      s1_v_d    = 1'b1;
      s1_last_d = final_strip && blk_last;
      s1_fin_d  = final_strip && strip_end;
      drain_d   = D_RUN;
      j_d       = j_q + 3'd1;
      if (j_q == 3'd7) begin
        drow_d = drow_q + 3'd1;
        if (drow_q == 3'd7) begin
          blk_d = blk_q + BW'(1);
          if (blk_last) begin
            blk_d     = {BW{1'b0}};
            rd_bank_d = ~rd_bank_q;
            dstrip_d  = dstrip_q + 16'd1;
            if (final_strip) begin
              drain_d = D_IDLE;
            end else if (bank_full_nxt[~rd_bank_q]) begin
              drain_d = D_RUN;
            end else begin
              drain_d = D_IDLE;
            end
          end else begin
            blk_d = blk_q + BW'(1);
          end
        end else begin
          drow_d = drow_q + 3'd1;
        end
      end else begin
        j_d = j_q + 3'd1;
      end
    end else begin
      s1_v_d = s1_v_q && !s2_take;
    end

    // Output register refills from the read stage whenever it is free or taken.
    if (s2_take) begin
      out_valid_d = s1_v_q;
      out_last_d  = s1_v_q && s1_last_q;
      out_fin_d   = s1_v_q && s1_fin_q;
      if (s1_v_q) begin
        out_data_d = {{(32-PIX_W){1'b0}}, s1_data_q};
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    if (out_valid_q && out_ready && out_fin_q) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      fill_d  = F_IDLE;
      drain_d = D_IDLE;
    end else begin
      done_d = 1'b0;
    end

    if (start && !busy_q) begin
      if (cfg_ok) begin
        busy_d = 1'b1;  cfg_w_d = cfg_width_blks;  cfg_h_d = cfg_height_strips;
        fill_d = F_FILL;  drain_d = D_IDLE;  bank_full_d = 2'b00;
        wr_bank_d = 1'b0;  rd_bank_d = 1'b0;
        col_d = {CW{1'b0}};  frow_d = 3'd0;  fstrip_d = 16'd0;
        blk_d = {BW{1'b0}};  drow_d = 3'd0;  j_d = 3'd0;  dstrip_d = 16'd0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_err_d = 1'b0;
    end

    in_ready_d = busy_d && (fill_d == F_FILL);
  end

  // Pixel storage: fill-side write port, registered read port (read stage).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
    if (rd_en) s1_data_q <= mem[rd_addr];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;  cfg_w_q <= {BW{1'b0}};  cfg_h_q <= 16'd0;
      fill_q <= F_IDLE;  drain_q <= D_IDLE;  bank_full_q <= 2'b00;
      wr_bank_q <= 1'b0;  rd_bank_q <= 1'b0;
      col_q <= {CW{1'b0}};  frow_q <= 3'd0;  fstrip_q <= 16'd0;
      blk_q <= {BW{1'b0}};  drow_q <= 3'd0;  j_q <= 3'd0;  dstrip_q <= 16'd0;
      s1_v_q <= 1'b0;  s1_last_q <= 1'b0;  s1_fin_q <= 1'b0;
      out_valid_q <= 1'b0;  out_data_q <= 32'd0;  out_last_q <= 1'b0;  out_fin_q <= 1'b0;
      done_q <= 1'b0;  cfg_err_q <= 1'b0;  in_ready_q <= 1'b0;
    end else begin
      busy_q <= busy_d;  cfg_w_q <= cfg_w_d;  cfg_h_q <= cfg_h_d;
      fill_q <= fill_d;  drain_q <= drain_d;  bank_full_q <= bank_full_d;
      wr_bank_q <= wr_bank_d;  rd_bank_q <= rd_bank_d;
      col_q <= col_d;  frow_q <= frow_d;  fstrip_q <= fstrip_d;
      blk_q <= blk_d;  drow_q <= drow_d;  j_q <= j_d;  dstrip_q <= dstrip_d;
      s1_v_q <= s1_v_d;  s1_last_q <= s1_last_d;  s1_fin_q <= s1_fin_d;
      out_valid_q <= out_valid_d;  out_data_q <= out_data_d;
      out_last_q <= out_last_d;  out_fin_q <= out_fin_d;
      done_q <= done_d;  cfg_err_q <= cfg_err_d;  in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last_blk = out_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_jpeg_raster_to_block.sv
// Testbench for jpeg_raster_to_block: directed frames, expected beats queued
// at stimulus time and checked by an independent output monitor.
module tb_jpeg_raster_to_block;

  localparam int MAXW = 640;
  localparam int BW   = $clog2(MAXW/8) + 1;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, out_valid, out_ready;
  logic [BW-1:0] cfg_w;
  logic [15:0]   cfg_h;
  logic [23:0]   in_data;
  logic [31:0]   out_data;
  logic          out_last_blk, busy, done, cfg_err;

  int vectors = 0, errors = 0;
  int cyc = 0;
  int acc_cnt, done_cnt, done_cyc, first_vld_cyc, last_acc;
  bit rand_rdy, rdy_fixed;
  bit stall_pend;
  logic [31:0] stall_data;
  logic        stall_last;
  logic [32:0] exp_beat;
  logic [32:0] sb[$];

  jpeg_raster_to_block #(.MAX_WIDTH(MAXW), .PIX_W(24)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width_blks(cfg_w), .cfg_height_strips(cfg_h),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_blk(out_last_blk), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, want);
    end
  endtask

  // Expected beats in block order: raster index of (strip, blk*8+j, row).
  task automatic push_frame(input int w, input int h, input logic [7:0] id);
    for (int s = 0; s < h; s++)
      for (int b = 0; b < w; b++)
        for (int r = 0; r < 8; r++)
          for (int j = 0; j < 8; j++) begin
            int idx;
            logic lst;
            idx = s*64*w + r*8*w + b*8 + j;
            lst = (s == h-1) && (b == w-1);
            sb.push_back({lst, 8'h00, id, idx[15:0]});
          end
  endtask

  task automatic do_start(input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1; cfg_w = BW'(w); cfg_h = 16'(h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [23:0] px);
    int g;
    g = 0;
    in_valid = 1'b1; in_data = px;
    @(negedge clk);
    while (in_ready !== 1'b1 && g < 4000) begin @(negedge clk); g++; end
    if (in_ready !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL in_timeout: got in_ready=%0b after %0d cycles, required 1", in_ready, g);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic feed(input logic [7:0] id, input int n);
    for (int k = 0; k < n; k++) send({id, 16'(k)});
  endtask

  task automatic wait_done(input int budget);
    int g;
    g = 0;
    while (done_cnt == 0 && g < budget) begin @(posedge clk); g++; end
    if (done_cnt == 0) begin
      vectors++; errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, required one", budget);
    end
  endtask

  task automatic finish_frame(input string nm);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({nm, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({nm, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_out_data"}, out_data, 32'd0);
    chk({nm, "_out_last"}, {31'd0, out_last_blk}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done"}, {31'd0, done}, 32'd0);
    chk({nm, "_cfg_err"}, {31'd0, cfg_err}, 32'd0);
  endtask

  task automatic run_frame(input int w, input int h, input logic [7:0] id);
    push_frame(w, h, id);
    done_cnt = 0; first_vld_cyc = -1;
    do_start(w, h);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    feed(id, 64*w*h);
    wait_done(20000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 24'd0;
    cfg_w = {BW{1'b0}}; cfg_h = 16'd0;
    rand_rdy = 1'b0; rdy_fixed = 1'b1; stall_pend = 1'b0;
    acc_cnt = 0; done_cnt = 0; done_cyc = -1; first_vld_cyc = -1; last_acc = 0;
    fork
      // Output-ready driver.
      begin
        forever begin
          @(posedge clk); #1;
          out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : rdy_fixed;
        end
      end
      // Output monitor: pops the scoreboard on every handshake.
      begin
        forever begin
          @(negedge clk);
          if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
          if (in_valid && in_ready === 1'b1) acc_cnt++;
          if (out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
          if (stall_pend) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== stall_data || out_last_blk !== stall_last) begin
              errors++;
              $display("FAIL stall_hold: got valid=%0b data=%08h last=%0b, required valid=1 data=%08h last=%0b",
                       out_valid, out_data, out_last_blk, stall_data, stall_last);
            end
          end
          stall_pend = 1'b0;
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL beat_unexpected: got data=%08h last=%0b, required no beat", out_data, out_last_blk);
            end else begin
              exp_beat = sb.pop_front();
              if ({out_last_blk, out_data} !== exp_beat) begin
                errors++;
                $display("FAIL beat: got data=%08h last=%0b, required data=%08h last=%0b",
                         out_data, out_last_blk, exp_beat[31:0], exp_beat[32]);
              end
            end
          end else if (out_valid === 1'b1) begin
            stall_pend = 1'b1; stall_data = out_data; stall_last = out_last_blk;
          end
        end
      end
      // Directed stimulus.
      begin
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Rejected configurations.
        do_start(0, 1);
        chk("cfg_err_w0", {31'd0, cfg_err}, 32'd1);
        chk("busy_w0", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd0);
        do_start(MAXW/8 + 1, 1);
        chk("cfg_err_wmax", {31'd0, cfg_err}, 32'd1);
        chk("busy_wmax", {31'd0, busy}, 32'd0);
        do_start(1, 0);
        chk("cfg_err_h0", {31'd0, cfg_err}, 32'd1);
        chk("busy_h0", {31'd0, busy}, 32'd0);

        // W=1 H=1 with latency checks.
        run_frame(1, 1, 8'd0);
        chk("first_valid_latency", 32'(first_vld_cyc), 32'(last_acc + 1));
        chk("done_latency", 32'(done_cyc), 32'(last_acc + 65));
        finish_frame("w1h1");

        // W=2 H=1: two blocks in one strip.
        run_frame(2, 1, 8'd1);
        finish_frame("w2h1");

        // W=4 H=2 with a randomly stalling consumer.
        rand_rdy = 1'b1;
        run_frame(4, 2, 8'd2);
        rand_rdy = 1'b0; rdy_fixed = 1'b1;
        finish_frame("w4h2_rand");

        // W=1 H=3 with the consumer blocked: only two strips fit.
        push_frame(1, 3, 8'd3);
        rdy_fixed = 1'b0; done_cnt = 0; acc_cnt = 0;
        do_start(1, 3);
        fork
          feed(8'd3, 192);
          begin
            repeat (300) @(posedge clk);
            #1;
            chk("accepted_while_stalled", 32'(acc_cnt), 32'd128);
            chk("in_ready_while_full", {31'd0, in_ready}, 32'd0);
            do_start(0, 0);
            chk("start_while_busy_no_err", {31'd0, cfg_err}, 32'd0);
            chk("start_while_busy_busy", {31'd0, busy}, 32'd1);
            rdy_fixed = 1'b1;
          end
        join
        wait_done(20000);
        finish_frame("w1h3_stall");

        // Reset part-way through a W=2 H=2 frame.
        done_cnt = 0;
        do_start(2, 2);
        feed(8'd4, 100);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("midreset");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset_no_done", 32'(done_cnt), 32'd0);

        // A fresh frame must carry no stale data.
        run_frame(1, 1, 8'd5);
        finish_frame("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
      end
    join
  end

endmodule
